sdp_ram_stream_reader: RTL and testbench

- Drains a block of words from port B of the ABM simple dual-port RAM and presents them as an AXI-Stream master.
- Drives the RAM read address, absorbs the RAM's fixed read latency, and honours downstream back-pressure without dropping or duplicating words.
- Sits directly downstream of the RAM. The ABM manager's control logic launches one burst at a time.

---
 rtl/sdp_ram_stream_reader.sv | 240 ++++++++++++++++++++++++
 tb/tb_sdp_ram_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_stream_reader.sv
// Streams a burst of words read from port B of a simple dual-port RAM out as an AXI-Stream master.
// Define SDP_RAM_STREAM_READER_LAT2_EN for a RAM with a two-cycle read latency (default is one cycle).
module sdp_ram_stream_reader #(
  parameter int DW = 512,
  parameter int DD = 16384,
  parameter int AW = $clog2(DD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tvalid,
  input  logic          axis_out_tready,
  output logic          axis_out_tlast
);

`ifdef SDP_RAM_STREAM_READER_LAT2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int FD = LAT + 1;
  localparam int CW = $clog2(FD + 1);
  localparam int SW = CW + 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] addrb_r, addrb_s;
  logic [AW:0]   words_to_issue_r, words_to_issue_s;
  logic [AW:0]   words_to_send_r, words_to_send_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          accept_s;
  logic          issue_s;
  logic [LAT-1:0] rd_pipe_r;
  logic [CW-1:0] inflight_s;
  logic [CW-1:0] occ_r, occ_s;
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [DW-1:0] fifo_mem_r [FD];
  logic          arrive_s;
  logic          fifo_ne_s;
  logic          xfer_s;
  logic          push_s;
  logic          pop_s;
  logic          room_s;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    if (a == LAST_ADDR) begin
      r = {AW{1'b0}};
    end else begin
      r = a + {{(AW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(FD - 1)) begin
      r = {PW{1'b0}};
    end else begin
      r = p + {{(PW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // The word arriving on dob bypasses the FIFO when it is empty, so first data appears with no extra stage.
  assign arrive_s        = rd_pipe_r[LAT-1];
  assign fifo_ne_s       = (occ_r != {CW{1'b0}});
  assign axis_out_tvalid = fifo_ne_s | arrive_s;
  assign axis_out_tdata  = fifo_ne_s ? fifo_mem_r[rd_ptr_r] : dob;
  assign axis_out_tlast  = axis_out_tvalid & (words_to_send_r == {{AW{1'b0}}, 1'b1});
  assign xfer_s          = axis_out_tvalid & axis_out_tready;
  assign push_s          = arrive_s & ~(~fifo_ne_s & xfer_s);
  assign pop_s           = xfer_s & fifo_ne_s;
  assign busy            = busy_r | accept_s;
  assign done            = done_r;
  assign addrb           = addrb_r;

  // Reads in flight plus buffered words must never exceed what the FIFO can hold.
  always_comb begin
    inflight_s = {CW{1'b0}};
    for (int i = 0; i < LAT; i++) begin
      inflight_s = inflight_s + {{(CW-1){1'b0}}, rd_pipe_r[i]};
    end
    room_s = (({1'b0, occ_r} + {1'b0, inflight_s}) < SW'(FD));
  end

  // FIFO occupancy update.
  always_comb begin
    occ_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_s = occ_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   occ_s = occ_r - {{(CW-1){1'b0}}, 1'b1};
      default: occ_s = occ_r;
    endcase
  end

  // Burst FSM next-state and control.
  always_comb begin
    state_s          = state_r;
    addrb_s          = addrb_r;
    words_to_issue_s = words_to_issue_r;
    busy_s           = busy_r;
    done_s           = 1'b0;
    accept_s         = 1'b0;
    issue_s          = 1'b0;
    if (xfer_s) begin
      words_to_send_s = words_to_send_r - {{AW{1'b0}}, 1'b1};
    end else begin
      words_to_send_s = words_to_send_r;
    end
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s         = 1'b1;
          addrb_s          = start_addr;
          words_to_issue_s = count;
          words_to_send_s  = count;
          if (count == {(AW+1){1'b0}}) begin
            state_s = FIN;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            state_s = READ;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (room_s && (words_to_issue_r != {(AW+1){1'b0}})) begin
          issue_s          = 1'b1;
          addrb_s          = addr_inc(addrb_r);
          words_to_issue_s = words_to_issue_r - {{AW{1'b0}}, 1'b1};
          if (words_to_issue_r == {{AW{1'b0}}, 1'b1}) begin
            state_s = DRAIN;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = READ;
        end
      end
      DRAIN: begin
        // Leave on the final transfer itself so done lands exactly one cycle after tlast.
        if ((words_to_send_r == {(AW+1){1'b0}}) ||
            (xfer_s && (words_to_send_r == {{AW{1'b0}}, 1'b1}))) begin
          state_s = FIN;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end else begin
          state_s = DRAIN;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      addrb_r          <= {AW{1'b0}};
      words_to_issue_r <= {(AW+1){1'b0}};
      words_to_send_r  <= {(AW+1){1'b0}};
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      state_r          <= state_s;
      addrb_r          <= addrb_s;
      words_to_issue_r <= words_to_issue_s;
      words_to_send_r  <= words_to_send_s;
      busy_r           <= busy_s;
      done_r           <= done_s;
    end
  end

  // Tracks which issued reads are due on dob in each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pipe_r <= {LAT{1'b0}};
    end else begin
      rd_pipe_r[0] <= issue_s;
      for (int i = 1; i < LAT; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      occ_r    <= {CW{1'b0}};
    end else begin
      occ_r <= occ_s;
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO storage; contents are qualified by occupancy and need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= dob;
    end
  end

endmodule

// File: tb/tb_sdp_ram_stream_reader.sv
// Scoreboard bench for sdp_ram_stream_reader: a RAM model holding data = address feeds the DUT,
// expected beats are queued at burst launch and a negedge monitor pops and compares them.
module tb_sdp_ram_stream_reader;
  localparam int DW = 16;
  localparam int DD = 12;
  localparam int AW = $clog2(DD);
`ifdef SDP_RAM_STREAM_READER_LAT2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dob;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_xfer_cyc = -1;
  int nbeats = 0;
  logic [DW:0] exp_q[$];
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [DW-1:0] mem [DD];

  sdp_ram_stream_reader #(.DW(DW), .DD(DD)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .start_addr      (start_addr),
    .count           (count),
    .busy            (busy),
    .done            (done),
    .addrb           (addrb),
    .dob             (dob),
    .axis_out_tdata  (tdata),
    .axis_out_tvalid (tvalid),
    .axis_out_tready (tready),
    .axis_out_tlast  (tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DD; i++) mem[i] = DW'(i);
  end

`ifdef SDP_RAM_STREAM_READER_LAT2_EN
  logic [DW-1:0] ram_d1;
  always @(posedge clk) begin
    ram_d1 <= mem[addrb];
    dob    <= ram_d1;
  end
`else
  always @(posedge clk) begin
    dob <= mem[addrb];
  end
`endif

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every transferred beat against the scoreboard and checks stall stability.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW:0]   e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_tvalid", 32'(tvalid), 32'd1);
          check("hold_tdata", 32'(tdata), 32'(prev_data));
          check("hold_tlast", 32'(tlast), 32'(prev_last));
        end
        if (tvalid && tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat actual=tdata %0d required=no beat (t=%0t)", tdata, $time);
          end else begin
            e = exp_q.pop_front();
            if (tdata !== e[DW-1:0] || tlast !== e[DW]) begin
              failures++;
              $display("FAIL beat actual=%0d/last%0d required=%0d/last%0d (t=%0t)",
                       tdata, tlast, e[DW-1:0], e[DW], $time);
            end
            if (e[DW]) last_xfer_cyc = cyc;
          end
          nbeats++;
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
      end
    end
  end

  // mode 0: tready held high; mode 1: tready follows pat. inj_k >= 0 pulses a stray start at that cycle.
  task automatic run_burst(input int saddr, input int cnt, input int mode, input int inj_k);
    int t0, first_v, done_cyc, done_busy, start_busy;
    logic [DW:0] e;
    for (int i = 0; i < cnt; i++) begin
      e[DW-1:0] = DW'((saddr + i) % DD);
      e[DW]     = (i == cnt - 1);
      exp_q.push_back(e);
    end
    first_v = -1; done_cyc = -1; done_busy = 0; start_busy = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(saddr); count = (AW+1)'(cnt); tready = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 300 && done_cyc < 0; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start  = 1'b0;
        tready = (mode == 1) ? pat[k % 6] : 1'b1;
        if (k == inj_k) begin
          start = 1'b1; start_addr = AW'(7); count = (AW+1)'(2);
        end
      end
      @(negedge clk);
      if (k == 0) start_busy = int'(busy);
      if (tvalid && first_v < 0) first_v = cyc;
      if (done) begin
        done_cyc  = cyc;
        done_busy = int'(busy);
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    check("busy_at_start", 32'(start_busy), 32'd1);
    check("busy_at_done", 32'(done_busy), 32'd0);
    if (done_cyc >= 0) begin
      if (cnt == 0) begin
        check("zero_no_tvalid", 32'(first_v), 32'hFFFF_FFFF);
        check("zero_done_latency", 32'(done_cyc - t0), 32'd1);
      end else begin
        check("done_after_tlast", 32'(done_cyc - last_xfer_cyc), 32'd1);
        if (mode == 0) begin
          check("first_tvalid_latency", 32'(first_v - t0), 32'(LAT + 1));
          check("burst_duration", 32'(done_cyc - t0), 32'(LAT + cnt + 1));
        end
      end
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int b0;
    logic [DW:0] e;
    reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; tready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_addrb", 32'(addrb), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_burst(2, 4, 0, -1);   // 2,3,4,5
    run_burst(2, 4, 1, -1);   // same burst under back-pressure
    run_burst(10, 4, 0, -1);  // 10,11,0,1
    run_burst(5, 0, 0, -1);   // zero length
    run_burst(5, DD, 0, -1);  // every location once
    run_burst(2, 6, 0, 3);    // stray start ignored
    run_burst(8, 3, 0, -1);   // launched the cycle after the previous done

    // Reset after two of eight beats.
    for (int i = 0; i < 8; i++) begin
      e[DW-1:0] = DW'((3 + i) % DD);
      e[DW]     = (i == 7);
      exp_q.push_back(e);
    end
    b0 = nbeats;
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(3); count = (AW+1)'(8); tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && nbeats < b0 + 2; k++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_beats", 32'(nbeats - b0), 32'd2);
    check("midrst_tvalid", 32'(tvalid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      check("midrst_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_no_done", 32'(done), 32'd0);
    run_burst(4, 5, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
